// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Optional sticky stack error flag: define PC_STACK_ERR_EN to enable.
module pc_ras #(
    parameter int D = 12,
    parameter int DEPTH = 4,
    parameter logic [D-1:0] RESET_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         jump_en,
    input  logic                         abs_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [D-1:0]                 target,
    output logic [D-1:0]                 prog_ctr,
    output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [D-1:0]  ras [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] adv_ptr;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  pc_nxt;
    logic [DW-1:0] depth_nxt;
    logic [PW-1:0] ptr_nxt;
    logic          do_push;

    // Circular pointer helpers: wr_ptr names the next free slot, which is
    // also the oldest entry once the stack is full.
    always_comb begin
        pc_inc  = prog_ctr + D'(1);
        top_ptr = (wr_ptr == '0) ? PW'(DEPTH-1) : wr_ptr - PW'(1);
        adv_ptr = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
    end

    // Next-state selection in priority order: ret > call > abs > jump > inc.
    always_comb begin
        pc_nxt    = pc_inc;
        depth_nxt = stack_depth;
        ptr_nxt   = wr_ptr;
        do_push   = 1'b0;
        if (ret_en) begin
            if (!stack_empty) begin
                pc_nxt    = ras[top_ptr];
                depth_nxt = stack_depth - DW'(1);
                ptr_nxt   = top_ptr;
            end
        end else if (call_en) begin
            pc_nxt  = target;
            ptr_nxt = adv_ptr;
            do_push = 1'b1;
            if (!stack_full) begin
                depth_nxt = stack_depth + DW'(1);
            end
        end else if (abs_en) begin
            pc_nxt = target;
        end else if (jump_en) begin
            pc_nxt = prog_ctr + target;
        end
    end

    // PC, stack pointer and registered depth flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr    <= RESET_ADDR;
            stack_depth <= '0;
            stack_full  <= 1'b0;
            stack_empty <= 1'b1;
            wr_ptr      <= '0;
        end else if (!stall) begin
            prog_ctr    <= pc_nxt;
            stack_depth <= depth_nxt;
            stack_full  <= (depth_nxt == DW'(DEPTH));
            stack_empty <= (depth_nxt == '0);
            wr_ptr      <= ptr_nxt;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!reset && !stall && do_push) begin
            ras[wr_ptr] <= pc_inc;
        end
    end

`ifdef PC_STACK_ERR_EN
    logic err_q;
    logic err_hit;

    // Overflow is a call that wins arbitration while full; underflow is a
    // return while empty.
    always_comb begin
        err_hit = (ret_en && stack_empty) ||
                  (!ret_en && call_en && stack_full);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!stall && err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras.sv
// Scoreboard testbench for pc_ras (D=12, DEPTH=4, RESET_ADDR=0).
module tb_pc_ras;

    typedef struct packed {
        logic [11:0] pc;
        logic [2:0]  depth;
        logic        full;
        logic        empty;
        logic        err;
    } st_t;

`ifdef PC_STACK_ERR_EN
    localparam logic EE = 1'b1;
`else
    localparam logic EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, jump_en, abs_en, call_en, ret_en;
    logic [11:0] target;
    logic [11:0] prog_ctr;
    logic [2:0]  stack_depth;
    logic        stack_full, stack_empty, stack_err;

    int tests = 0;
    int fails = 0;

    st_t   sb[$];
    st_t   obs[$];
    string names[$];

    pc_ras #(.D(12), .DEPTH(4), .RESET_ADDR(12'd0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .jump_en(jump_en), .abs_en(abs_en),
        .call_en(call_en), .ret_en(ret_en),
        .target(target), .prog_ctr(prog_ctr),
        .stack_depth(stack_depth), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of controls, queue the expected state, capture DUT.
    task automatic step(input string nm,
                        input logic r, input logic s, input logic rt,
                        input logic c, input logic a, input logic j,
                        input logic [11:0] t, input logic [11:0] epc,
                        input int ed, input logic eerr);
        st_t e;
        reset = r; stall = s; ret_en = rt;
        call_en = c; abs_en = a; jump_en = j; target = t;
        e.pc = epc;
        e.depth = 3'(ed);
        e.full = (ed == 4);
        e.empty = (ed == 0);
        e.err = eerr;
        sb.push_back(e);
        names.push_back(nm);
        @(posedge clk);
        #1;
        obs.push_back({prog_ctr, stack_depth, stack_full,
                       stack_empty, stack_err});
    endtask

    task automatic test_reset();
        step("rst0", 1,0,0,0,0,0, 12'h0, 12'd0, 0, 0);
        step("rst1", 1,0,0,0,0,0, 12'h0, 12'd0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step("idle", 0,0,0,0,0,0, 12'h0, 12'(i), 0, 0);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_jump();
        step("abs10",  0,0,0,0,1,0, 12'd10,   12'd10,   0, 0);
        step("jmp-3",  0,0,0,0,0,1, 12'hFFD,  12'd7,    0, 0);
        step("jmp0",   0,0,0,0,0,1, 12'h000,  12'd7,    0, 0);
        step("jmp+5",  0,0,0,0,0,1, 12'd5,    12'd12,   0, 0);
        step("abs4094",0,0,0,0,1,0, 12'd4094, 12'd4094, 0, 0);
        step("inc",    0,0,0,0,0,0, 12'h123,  12'd4095, 0, 0);
        step("wrap",   0,0,0,0,0,0, 12'h0,    12'd0,    0, 0);
        step("inc1",   0,0,0,0,0,0, 12'h0,    12'd1,    0, 0);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL jump/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_call_ret();
        step("abs20",  0,0,0,0,1,0, 12'd20,  12'd20,  0, 0);
        step("call",   0,0,0,1,0,0, 12'd100, 12'd100, 1, 0);
        step("stallc", 0,1,0,1,0,0, 12'd200, 12'd100, 1, 0);
        step("stallr", 0,1,1,0,0,0, 12'd0,   12'd100, 1, 0);
        step("inc",    0,0,0,0,0,0, 12'd0,   12'd101, 1, 0);
        step("ret",    0,0,1,0,0,0, 12'd999, 12'd21,  0, 0);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL call_ret/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_nested();
        step("abs1",  0,0,0,0,1,0, 12'd1,  12'd1,  0, 0);
        step("call1", 0,0,0,1,0,0, 12'd11, 12'd11, 1, 0);
        step("call2", 0,0,0,1,0,0, 12'd21, 12'd21, 2, 0);
        step("call3", 0,0,0,1,0,0, 12'd31, 12'd31, 3, 0);
        step("call4", 0,0,0,1,0,0, 12'd41, 12'd41, 4, 0);
        step("call5", 0,0,0,1,0,0, 12'd51, 12'd51, 4, EE);
        step("ret1",  0,0,1,0,0,0, 12'd0,  12'd42, 3, EE);
        step("ret2",  0,0,1,0,0,0, 12'd0,  12'd32, 2, EE);
        step("ret3",  0,0,1,0,0,0, 12'd0,  12'd22, 1, EE);
        step("ret4",  0,0,1,0,0,0, 12'd0,  12'd12, 0, EE);
        step("ret5",  0,0,1,0,0,0, 12'd77, 12'd13, 0, EE);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL nested/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_priority();
        step("abs49",   0,0,0,0,1,0, 12'd49,  12'd49,  0, EE);
        step("call300", 0,0,0,1,0,0, 12'd300, 12'd300, 1, EE);
        step("rcj",     0,0,1,1,0,1, 12'd500, 12'd50,  0, EE);
        step("aj7",     0,0,0,0,1,1, 12'd7,   12'd7,   0, EE);
        step("ca60",    0,0,0,1,1,1, 12'd60,  12'd60,  1, EE);
        step("ret8",    0,0,1,0,0,0, 12'd0,   12'd8,   0, EE);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL priority/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        step("abs70",   0,0,0,0,1,0, 12'd70,  12'd70,  0, EE);
        step("call200", 0,0,0,1,0,0, 12'd200, 12'd200, 1, EE);
        step("ret",     0,0,1,0,0,0, 12'd0,   12'd71,  0, EE);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        step("c100", 0,0,0,1,0,0, 12'd100, 12'd100, 1, EE);
        step("c200", 0,0,0,1,0,0, 12'd200, 12'd200, 2, EE);
        step("c300", 0,0,0,1,0,0, 12'd300, 12'd300, 3, EE);
        step("rst",  1,0,1,1,0,1, 12'd400, 12'd0,   0, 0);
        step("ret",  0,0,1,0,0,0, 12'd0,   12'd1,   0, EE);
        while (sb.size() > 0) begin
            st_t e = sb.pop_front();
            st_t o = obs.pop_front();
            string n = names.pop_front();
            tests++;
            if (o !== e) begin
                fails++;
                $display("FAIL mid_reset/%s got %h expected %h", n, o, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jump_en = 1'b0; abs_en = 1'b0;
        call_en = 1'b0; ret_en = 1'b0; target = '0;
        test_reset();
        test_jump();
        test_call_ret();
        test_nested();
        test_priority();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
